parking_lane_arbiter: RTL

- Controller for a single shared ramp lane used by both entering and exiting cars.
- Arbitrates ENTRY_req and EXIT_req, opens one gate at a time and waits for the car to pass.
- Issues single-cycle ENTRY_pulse/EXIT_pulse to the Parking_Management_System occupancy counter (its ENTRY_sensor/EXIT_sensor inputs).
- Uses the counter's FULL/EMPTY to block invalid moves.

---
 rtl/parking_lane_arbiter_if.sv | 31 +++
 rtl/parking_lane_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/parking_lane_arbiter_if.sv
// Signal bundle between the shared-lane arbiter and its surroundings:
// car requests, pass sensor and counter status in, barrier controls and
// counter strobes out.
interface parking_lane_arbiter_if;
    logic ENTRY_req;
    logic EXIT_req;
    logic PASS_sensor;
    logic FULL;
    logic EMPTY;
    logic ENTRY_gate;
    logic EXIT_gate;
    logic ENTRY_pulse;
    logic EXIT_pulse;
    logic ENTRY_denied;
    logic TIMEOUT;
    logic BUSY;

    // Environment side: drives requests/sensors/counter status, observes the lane.
    modport master (
        output ENTRY_req, EXIT_req, PASS_sensor, FULL, EMPTY,
        input  ENTRY_gate, EXIT_gate, ENTRY_pulse, EXIT_pulse,
               ENTRY_denied, TIMEOUT, BUSY
    );

    // Arbiter side.
    modport slave (
        input  ENTRY_req, EXIT_req, PASS_sensor, FULL, EMPTY,
        output ENTRY_gate, EXIT_gate, ENTRY_pulse, EXIT_pulse,
               ENTRY_denied, TIMEOUT, BUSY
    );
endinterface

// File: rtl/parking_lane_arbiter.sv
// Single-lane ramp arbiter: grants the shared lane to one direction at a
// time, holds the gate open until the car passes or the open window expires,
// strobes the occupancy counter on a real pass, then keeps both barriers
// closed for a short guard interval before arbitrating again.
module parking_lane_arbiter #(
    parameter int OPEN_CYCLES  = 8,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic CLK,
    input  logic RESET,
    parking_lane_arbiter_if.slave lane
);

    localparam int TW = (OPEN_CYCLES  > 2) ? $clog2(OPEN_CYCLES)  : 1;
    localparam int GW = (CLEAR_CYCLES > 2) ? $clog2(CLEAR_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY_OPEN,
        EXIT_OPEN,
        GUARD
    } state_t;

    typedef enum logic {
        GRANT_ENTRY,
        GRANT_EXIT
    } side_t;

    state_t        state;
    side_t         last_grant;
    logic [TW-1:0] timer;
    logic [GW-1:0] guard_cnt;

    logic entry_gate_q;
    logic exit_gate_q;
    logic entry_pulse_q;
    logic exit_pulse_q;
    logic entry_denied_q;
    logic timeout_q;
    logic busy_q;

    logic ent_v;
    logic ext_v;
    logic grant_entry;
    logic grant_exit;

    // Qualify requests against counter status and resolve ties round-robin.
    always_comb begin
        ent_v       = lane.ENTRY_req & ~lane.FULL;
        ext_v       = lane.EXIT_req  & ~lane.EMPTY;
        grant_entry = ent_v & (~ext_v | (last_grant == GRANT_EXIT));
        grant_exit  = ext_v & ~grant_entry;
    end

    // Lane controller: state, timers, round-robin memory and all registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state          <= IDLE;
            last_grant     <= GRANT_EXIT;
            timer          <= '0;
            guard_cnt      <= '0;
            entry_gate_q   <= 1'b0;
            exit_gate_q    <= 1'b0;
            entry_pulse_q  <= 1'b0;
            exit_pulse_q   <= 1'b0;
            entry_denied_q <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            entry_pulse_q  <= 1'b0;
            exit_pulse_q   <= 1'b0;
            timeout_q      <= 1'b0;
            entry_denied_q <= 1'b0;

            case (state)
                IDLE: begin
                    entry_denied_q <= lane.ENTRY_req & lane.FULL;
                    if (grant_entry) begin
                        state        <= ENTRY_OPEN;
                        entry_gate_q <= 1'b1;
                        busy_q       <= 1'b1;
                        timer        <= '0;
                        last_grant   <= GRANT_ENTRY;
                    end else if (grant_exit) begin
                        state        <= EXIT_OPEN;
                        exit_gate_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        timer        <= '0;
                        last_grant   <= GRANT_EXIT;
                    end
                end

                ENTRY_OPEN, EXIT_OPEN: begin
                    if (lane.PASS_sensor) begin
                        state         <= GUARD;
                        guard_cnt     <= '0;
                        entry_gate_q  <= 1'b0;
                        exit_gate_q   <= 1'b0;
                        entry_pulse_q <= (state == ENTRY_OPEN);
                        exit_pulse_q  <= (state == EXIT_OPEN);
                    end else if (timer == TW'(OPEN_CYCLES - 1)) begin
                        state         <= GUARD;
                        guard_cnt     <= '0;
                        entry_gate_q  <= 1'b0;
                        exit_gate_q   <= 1'b0;
                        timeout_q     <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                GUARD: begin
                    if (guard_cnt == GW'(CLEAR_CYCLES - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end

                default: begin
                    state        <= IDLE;
                    entry_gate_q <= 1'b0;
                    exit_gate_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign lane.ENTRY_gate   = entry_gate_q;
    assign lane.EXIT_gate    = exit_gate_q;
    assign lane.ENTRY_pulse  = entry_pulse_q;
    assign lane.EXIT_pulse   = exit_pulse_q;
    assign lane.ENTRY_denied = entry_denied_q;
    assign lane.TIMEOUT      = timeout_q;
    assign lane.BUSY         = busy_q;

endmodule
